// File: rtl/rx_frame_scheduler.sv
// Purpose: drains completed ping-pong RAM banks to one valid/ready byte stream, releasing each bank after its last byte.
// Latency: interrupt at T -> first rd_en at T+2, first byte at T+3; N-byte frame releases its bank at T+4+N.
// Backpressure: reads stay at most 2 bytes ahead of the consumer (skid plus in-flight); out_* hold while !out_ready.
module rx_frame_scheduler #(
  parameter int FRAMECNT = 64,
  parameter int ADDRW    = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [1:0]       frame_interrupt,
  input  logic [10:0]      frame_count,
  output logic             rd_en,
  output logic [ADDRW:0]   rd_addr,
  input  logic [7:0]       rd_data,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [1:0]       bank_release,
  output logic             overrun,
  output logic [7:0]       overrun_cnt,
  output logic             busy
);

  localparam int LENW = ADDRW + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_RELEASE} state_t;

  state_t            state, state_n;
  logic [1:0]        pending;
  logic [LENW-1:0]   len_q [2];
  logic              next_bank;
  logic              active;
  logic              active_vld;
  logic [LENW-1:0]   idx;
  logic              inflight;
  logic              inflight_last;
  logic [8:0]        skid0, skid1;
  logic [1:0]        skid_cnt;

  logic [1:0]        drop, capture;
  logic [LENW-1:0]   clamp_len;
  logic [LENW-1:0]   cur_len;
  logic              sel_bank;
  logic              start;
  logic              pop_skid, byp, push;
  logic [8:0]        rd_word;
  logic [8:0]        head;

  // Interrupt qualification: a bank still queued or being drained cannot take a new frame.
  always_comb begin
    drop    = 2'b00;
    capture = 2'b00;
    for (int b = 0; b < 2; b++) begin
      drop[b]    = frame_interrupt[b] && (pending[b] || (active_vld && (active == 1'(b))));
      capture[b] = frame_interrupt[b] && !drop[b];
    end
    clamp_len = (frame_count > 11'(FRAMECNT)) ? LENW'(FRAMECNT) : LENW'(frame_count);
    cur_len   = len_q[active];
    sel_bank  = pending[next_bank] ? next_bank : ~next_bank;
  end

  // Next-state and read strobe; reads are throttled so skid plus in-flight never exceeds 2.
  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    start   = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && (pending != 2'b00)) begin
          state_n = S_READ;
          start   = 1'b1;
        end
      end
      S_READ: begin
        if (cur_len == '0) begin
          state_n = S_RELEASE;
        end else if ((idx < cur_len) && (({1'b0, skid_cnt} + {2'b00, inflight}) < 3'd2)) begin
          rd_en = 1'b1;
          if ((idx + LENW'(1)) == cur_len) state_n = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if ((skid_cnt == 2'd0) && !inflight) state_n = S_RELEASE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // Bank bookkeeping: pending flags, clamped lengths, active bank, read index, fairness pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending    <= 2'b00;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      next_bank  <= 1'b0;
      active     <= 1'b0;
      active_vld <= 1'b0;
      idx        <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (capture[b]) begin
          pending[b] <= 1'b1;
          len_q[b]   <= clamp_len;
        end
      end
      if (start) begin
        pending[sel_bank] <= 1'b0;
        active            <= sel_bank;
        active_vld        <= 1'b1;
        idx               <= '0;
      end else if (rd_en) begin
        idx <= idx + LENW'(1);
      end
      if (state == S_RELEASE) begin
        next_bank  <= ~active;
        active     <= 1'b0;
        active_vld <= 1'b0;
      end
    end
  end

  // Returning RAM byte bypasses straight to the output when the skid is empty and the consumer is ready.
  always_comb begin
    rd_word  = {inflight_last, rd_data};
    pop_skid = (skid_cnt != 2'd0) && out_ready;
    byp      = inflight && (skid_cnt == 2'd0) && out_ready;
    push     = inflight && !byp;
    if (skid_cnt != 2'd0) head = skid0;
    else if (inflight)    head = rd_word;
    else                  head = 9'd0;
  end

  // Read pipeline tracking and 2-entry skid buffer (skid0 is the head).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      skid0         <= 9'd0;
      skid1         <= 9'd0;
      skid_cnt      <= 2'd0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en && ((idx + LENW'(1)) == cur_len);
      case ({push, pop_skid})
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= rd_word;
          end else begin
            skid0 <= skid1;
            skid1 <= rd_word;
          end
        end
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= rd_word;
          else                  skid1 <= rd_word;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Overrun pulse and saturating counter; a double drop in one cycle counts once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun     <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      overrun <= |drop;
      if ((|drop) && (overrun_cnt != 8'hff)) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  assign out_valid    = (skid_cnt != 2'd0) || inflight;
  assign out_data     = head[7:0];
  assign out_last     = head[8];
  assign rd_addr      = rd_en ? {active, idx[ADDRW-1:0]} : '0;
  assign bank_release = (state == S_RELEASE) ? (active ? 2'b10 : 2'b01) : 2'b00;
  assign busy         = (state != S_IDLE);

endmodule

// File: doc/rx_frame_scheduler.md
Name: rx_frame_scheduler

Overview:
- Readout controller for the ping-pong frame buffer written by the UART frame receiver.
- Latches per-bank "frame complete" interrupts and frame lengths, then picks which bank to drain.
- Sequences RAM reads with 1-cycle read latency and streams bytes to one downstream consumer over valid/ready.
- Releases each bank back to the receiver when its frame has been fully delivered; flags overruns.

Parameters:
FRAMECNT, 64, maximum frame length in bytes; larger reported lengths are clamped to this value.
ADDRW, 6, per-bank address width; 2**ADDRW must be >= FRAMECNT.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
enable  in  1  when low, no new frame is started; a frame already in progress completes
frame_interrupt  in  2  one-cycle pulse per bank: bank b holds a complete frame
frame_count  in  11  length of the completed frame; sampled in any cycle where frame_interrupt is nonzero
rd_en  out  1  RAM read strobe
rd_addr  out  ADDRW+1  {bank, byte index}
rd_data  in  8  RAM data, valid exactly 1 cycle after rd_en
out_valid  out  1  output byte valid
out_data  out  8  output byte
out_last  out  1  marks the final byte of a frame; qualified by out_valid
out_ready  in  1  consumer accepts when out_valid && out_ready
bank_release  out  2  one-cycle pulse: bank b is free for writing
overrun  out  1  one-cycle pulse: interrupt arrived for a bank still pending or being read
overrun_cnt  out  8  saturating count of overrun pulses
busy  out  1  high in any state other than IDLE

Behaviour:
Reset values:
- All outputs are 0 on reset.
- pending[1:0]=0, both stored lengths=0, next_bank=0, skid buffer empty.
- Reset mid-frame aborts the frame with no release pulse and no out_last.

Interrupt capture (per bank b, on frame_interrupt[b]):
- If bank b is neither pending nor active: set pending[b], store len[b] = min(frame_count, FRAMECNT).
- If bank b is pending or active: drop the event, pulse overrun on the next cycle, increment overrun_cnt (saturates at 255), leave len[b] unchanged.
- Both bits in the same cycle: both banks captured, each checked independently. Both share the same frame_count sample.
- If both drop in the same cycle, overrun pulses once and overrun_cnt increments by 1.

FSM states: IDLE, READ, FLUSH, RELEASE.
- IDLE -> READ when enable && pending nonzero.
  - Bank selection: next_bank if pending[next_bank], otherwise the other bank.
  - On entry: active=bank, clear pending[bank], idx=0.
- READ:
  - Assert rd_en when idx<len and (skid occupancy + reads in flight) < 2; idx increments on each rd_en.
  - The rd_data return is pushed into a 2-entry skid buffer that drives out_data/out_valid.
  - After the final rd_en (idx reaches len) -> FLUSH.
- FLUSH -> RELEASE when the skid buffer is empty and the last byte has been accepted.
- RELEASE: one cycle.
  - bank_release[active]=1; next_bank = ~active; active cleared.
  - -> IDLE.
- len==0: IDLE -> READ -> RELEASE directly; no rd_en and no out_valid, release pulse still issued.

Output rules:
- out_last is high with the byte whose index equals len-1.
- out_valid/out_data are held stable while !out_ready.
- No bubble under continuous out_ready: one byte per cycle.

Latency:
- Interrupt in cycle T: pending visible at T+1, first rd_en at T+2, first out_valid at T+3.
- A frame of N bytes with out_ready held high: last byte is accepted at T+2+N, bank_release pulses at T+4+N.

enable:
- Sampled only in IDLE.
- Deassertion during READ/FLUSH does not stall the frame.
- Interrupts are still captured while enable is low.

Test Plan:
1. Bank 0 interrupt with frame_count=4, RAM bytes 11,22,33,44, out_ready=1 -> rd_addr 0..3 on consecutive cycles; out_data 11,22,33,44 with out_last on 44; bank_release=01 one pulse; busy low afterwards.
2. Interrupts on banks 0 and 1 in the same cycle, lengths 3 -> bank 0 drained first, then bank 1 (rd_addr 64..66), with two separate release pulses in that order.
3. out_ready toggled 1,0,0,1 during a 5-byte frame -> no byte lost or duplicated; out_data stable while stalled; at most 2 reads ahead of the accepted byte.
4. Second bank 0 interrupt during readout of bank 0 -> overrun pulse, overrun_cnt=1; current frame completes unchanged; no extra frame delivered afterwards.
5. frame_count=200 -> exactly 64 bytes delivered, out_last on index 63. frame_count=0 -> no out_valid, bank_release still pulses.
6. enable=0 with bank 1 pending -> stays in IDLE. enable=1 -> frame delivered. resetn low mid-READ -> all outputs 0 immediately, no release pulse.
